rv_regfile_mp: RTL and testbench
================================

Name: rv_regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core. Generalises the current 2R/1W file to NRD read ports and NWR write ports.
- Adds an optional hard-wired zero entry and same-cycle write-to-read bypass.
- Adds a sequential bulk-clear engine with a busy/done handshake, used for hart restart without asserting rst.
- Sits between the decode stage (read ports) and the writeback stage (write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of entries; power of two, >=4. AW = $clog2(NREGS).
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- ZERO_REG, 1, when 1, entry 0 reads as zero and ignores writes.
- BYPASS, 1, when 1, reads return the data being written in the same cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  NWR  per-port write enable.
- waddr  in  NWR*AW  write addresses; port p at bits [p*AW +: AW].
- wdata  in  NWR*XLEN  write data; port p at bits [p*XLEN +: XLEN].
- raddr  in  NRD*AW  read addresses, packed the same way.
- rdata  out  NRD*XLEN  read data; combinational from raddr, array and write ports.
- clr_req  in  1  request a bulk clear; level-sampled only in IDLE.
- clr_busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (async, rst=1): all entries 0, FSM=IDLE, clear counter 0, clr_busy=0, clr_done=0. rdata follows the zeroed array. Reset asserted mid-sweep aborts the sweep immediately.
- Writes: on a rising edge with we[p]=1, entry waddr[p] <= wdata[p].
  - ZERO_REG=1: writes to address 0 are dropped.
  - Two ports to the same address in one cycle: the higher port index wins.
- Reads: rdata[r] = array[raddr[r]], combinational, zero latency.
  - ZERO_REG=1 and raddr[r]=0: rdata[r]=0 regardless of the array or writes.
  - BYPASS=1: if any port has we[p]=1 and waddr[p]=raddr[r] (and the address is non-zero when ZERO_REG=1), rdata[r]=wdata of the highest such p.
  - BYPASS=0: rdata shows the pre-edge contents; the new value is visible after the edge.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 at edge k -> SWEEP, counter=0.
  - SWEEP: at each edge, entry[counter] <= 0 and counter++. When counter = NREGS-1, that edge clears the last entry and moves to DONE. Entries are cleared at edges k+1 .. k+NREGS.
  - DONE: clr_done=1 for exactly one cycle, then -> IDLE.
  - clr_busy=1 exactly while state=SWEEP, i.e. NREGS cycles.
  - clr_req is ignored in SWEEP and DONE. If it is still high in IDLE it is re-sampled and starts a new sweep.
- While clr_busy=1:
  - All we[] are masked (user writes dropped, no bypass).
  - Reads return the current array contents, which are partially cleared.
  - Counter width is AW; the counter never wraps during a sweep.
- After DONE: all entries read 0 and normal writes resume in IDLE.

Decomposition:
- Shared package rv_pkg: XLEN default, REG_AW, the clear FSM state enum (IDLE/SWEEP/DONE), and the ABI constant REG_ZERO=0.
- One sub-module: rv_regfile_clr_fsm, holding the FSM, counter, clr_busy, clr_done, the clear write strobe and address. The array, write arbitration and bypass muxing stay in the top module.

Test Plan:
- Reset then read: rst pulse, raddr={5,0} -> rdata={0,0}. rst asserted between clock edges clears the array without a clock edge.
- Write/read and zero register: we=1, waddr=7, wdata=0xDEADBEEF at edge n, then raddr=7 -> 0xDEADBEEF. Write 0x1234 to address 0 -> read of address 0 returns 0.
- Bypass: BYPASS=1, we=1, waddr=3, wdata=0xA5A5A5A5, raddr=3 in the same cycle -> rdata=0xA5A5A5A5 before the edge. With BYPASS=0 -> old value (0) until the edge.
- Write conflict: NWR=2, both ports write address 9, port0=0x11, port1=0x22 -> entry 9 = 0x22, and bypass shows 0x22.
- Bulk clear: preload all entries with index+1, pulse clr_req -> clr_busy high for 32 cycles, clr_done high on cycle 33 for one cycle. Every read then returns 0. A we=1 to address 4 during busy is dropped, and entry 4 reads 0 afterwards.
- Reset mid-sweep: assert rst 10 cycles into a sweep -> clr_busy=0 and clr_done=0 immediately, FSM returns to IDLE, all entries 0. A new clr_req afterwards completes a full 32-cycle sweep.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and clear-FSM state type for the RISC-V core register files
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_t;
endpackage

// File: rtl/rv_regfile_clr_fsm.sv
// rv_regfile_clr_fsm: sequential bulk-clear engine with busy/done handshake
module rv_regfile_clr_fsm #(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  import rv_pkg::*;
  clr_state_t state;
  logic [AW-1:0] cnt;
  // sweep one entry per cycle; busy and done are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= SWEEP;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt == AW'(NREGS - 1)) begin
            state    <= DONE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end
  assign clr_we   = state == SWEEP;
  assign clr_addr = cnt;
endmodule

// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp: multi-port integer register file with zero entry, bypass and bulk clear
module rv_regfile_mp #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);
  import rv_pkg::*;
  logic [XLEN-1:0] regs [NREGS];
  logic [NWR-1:0] we_eff;
  logic clr_we;
  logic [AW-1:0] clr_addr;
  rv_regfile_clr_fsm #(.NREGS(NREGS)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  // user writes are masked during a sweep and dropped at the hard-wired zero entry
  always_comb begin
    we_eff = '0;
    for (int p = 0; p < NWR; p++)
      we_eff[p] = we[p] && !clr_busy && !(ZERO_REG != 0 && waddr[p*AW +: AW] == AW'(REG_ZERO));
  end
  // array update: clear sweep, else user writes with the higher port applied last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (we_eff[p]) regs[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
    end
  end
  // read muxing: array, then highest matching write port, then zero entry override
  always_comb begin
    rdata = '0;
    for (int r = 0; r < NRD; r++) begin
      rdata[r*XLEN +: XLEN] = regs[raddr[r*AW +: AW]];
      if (BYPASS != 0)
        for (int p = 0; p < NWR; p++)
          if (we_eff[p] && waddr[p*AW +: AW] == raddr[r*AW +: AW])
            rdata[r*XLEN +: XLEN] = wdata[p*XLEN +: XLEN];
      if (ZERO_REG != 0 && raddr[r*AW +: AW] == AW'(REG_ZERO)) rdata[r*XLEN +: XLEN] = '0;
    end
  end
endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb_rv_regfile_mp: scoreboard bench for the multi-port register file
module tb_rv_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_req = 1'b0;
  logic [1:0] we_a;
  logic [9:0] waddr_a, raddr_a;
  logic [63:0] wdata_a, rdata_a;
  logic busy_a, done_a;
  logic [0:0] we_b;
  logic [4:0] waddr_b, raddr_b;
  logic [31:0] wdata_b, rdata_b;
  logic busy_b, done_b;
  int passed = 0;
  int total = 0;
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;
  chk_t q[$];
  chk_t c;
  logic [31:0] act;

  rv_regfile_mp #(.NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .raddr(raddr_a), .rdata(rdata_a), .clr_req(clr_req),
    .clr_busy(busy_a), .clr_done(done_a)
  );
  rv_regfile_mp #(.NRD(1), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .raddr(raddr_b), .rdata(rdata_b), .clr_req(1'b0),
    .clr_busy(busy_b), .clr_done(done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: expired wait after %0d/%0d checks", passed, total);
    $finish;
  end

  function automatic logic [31:0] sel(input int k);
    case (k)
      0: return rdata_a[31:0];
      1: return rdata_a[63:32];
      2: return rdata_b;
      3: return {31'd0, busy_a};
      default: return {31'd0, done_a};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      c = q.pop_front();
      act = sel(c.kind);
      total++;
      if (act === c.exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string n, input int k, input logic [31:0] e);
    chk_t t;
    t.name = n;
    t.kind = k;
    t.exp = e;
    q.push_back(t);
  endtask

  task automatic wa(input int p, input logic en, input logic [4:0] ad, input logic [31:0] d);
    we_a[p] = en;
    waddr_a[p*5 +: 5] = ad;
    wdata_a[p*32 +: 32] = d;
  endtask

  task automatic ra(input int p, input logic [4:0] ad);
    raddr_a[p*5 +: 5] = ad;
  endtask

  task automatic sweep(input string tag, input bit mid);
    for (int n = 1; n <= 32; n++) begin
      step();
      if (n == 1) clr_req = 1'b0;
      expect_val({tag, "_busy"}, 3, 32'd1);
      if (mid && n == 3) begin
        wa(0, 1'b1, 5'd4, 32'h99);
        ra(0, 5'd4);
        expect_val({tag, "_mask4"}, 0, 32'd5);
      end
      if (mid && n == 4) wa(0, 1'b0, 5'd0, 32'd0);
      if (mid && n == 32) expect_val({tag, "_last31"}, 1, 32'd32);
    end
    step();
    expect_val({tag, "_end_busy"}, 3, 32'd0);
    expect_val({tag, "_done"}, 4, 32'd1);
    step();
    expect_val({tag, "_done_drop"}, 4, 32'd0);
  endtask

  initial begin
    we_a = '0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
    we_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
    #2 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ra(0, 5'd5); ra(1, 5'd0); raddr_b = 5'd5;
    #1;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || rdata_a !== 64'd0 || rdata_b !== 32'd0)
      $display("FAIL reset_state: busy=%b done=%b rdata_a=0x%016h rdata_b=0x%08h", busy_a, done_a, rdata_a, rdata_b);
    expect_val("rst_rd5", 0, 32'd0);
    expect_val("rst_rd0", 1, 32'd0);
    expect_val("rst_rdb", 2, 32'd0);
    expect_val("rst_busy", 3, 32'd0);
    expect_val("rst_done", 4, 32'd0);
    step();
    wa(0, 1'b1, 5'd7, 32'hDEADBEEF); ra(0, 5'd7);
    expect_val("w7_byp", 0, 32'hDEADBEEF);
    step();
    wa(0, 1'b0, 5'd0, 32'd0);
    expect_val("w7_rd", 0, 32'hDEADBEEF);
    wa(1, 1'b1, 5'd0, 32'h1234); ra(1, 5'd0);
    expect_val("zero_byp", 1, 32'd0);
    step();
    wa(1, 1'b0, 5'd0, 32'd0);
    expect_val("zero_rd", 1, 32'd0);
    step();
    wa(0, 1'b1, 5'd3, 32'hA5A5A5A5); ra(0, 5'd3);
    we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'hA5A5A5A5; raddr_b = 5'd3;
    expect_val("byp_on", 0, 32'hA5A5A5A5);
    expect_val("byp_off_old", 2, 32'd0);
    step();
    wa(0, 1'b0, 5'd0, 32'd0); we_b = 1'b0;
    expect_val("byp_on_after", 0, 32'hA5A5A5A5);
    expect_val("byp_off_after", 2, 32'hA5A5A5A5);
    step();
    wa(0, 1'b1, 5'd9, 32'h11); wa(1, 1'b1, 5'd9, 32'h22); ra(0, 5'd9); ra(1, 5'd9);
    expect_val("conf_byp0", 0, 32'h22);
    expect_val("conf_byp1", 1, 32'h22);
    step();
    wa(0, 1'b0, 5'd0, 32'd0); wa(1, 1'b0, 5'd0, 32'd0);
    expect_val("conf_rd", 0, 32'h22);
    step();
    ra(0, 5'd7); ra(1, 5'd9); raddr_b = 5'd3;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    expect_val("arst_rd7", 0, 32'd0);
    expect_val("arst_rd9", 1, 32'd0);
    expect_val("arst_rdb", 2, 32'd0);
    step();
    for (int i = 1; i < 32; i++) begin
      wa(0, 1'b1, 5'(i), 32'(i + 1));
      step();
    end
    wa(0, 1'b0, 5'd0, 32'd0);
    ra(0, 5'd4); ra(1, 5'd31);
    expect_val("pre_rd4", 0, 32'd5);
    expect_val("pre_rd31", 1, 32'd32);
    expect_val("pre_busy", 3, 32'd0);
    clr_req = 1'b1;
    sweep("clr", 1'b1);
    for (int i = 0; i < 16; i++) begin
      ra(0, 5'(2 * i)); ra(1, 5'(2 * i + 1));
      expect_val($sformatf("cleared_%0d", 2 * i), 0, 32'd0);
      expect_val($sformatf("cleared_%0d", 2 * i + 1), 1, 32'd0);
      step();
    end
    wa(0, 1'b1, 5'd10, 32'hABC);
    step();
    wa(0, 1'b0, 5'd0, 32'd0); ra(0, 5'd10);
    expect_val("pre_rd10", 0, 32'hABC);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    expect_val("mid_busy", 3, 32'd1);
    expect_val("mid_rd10", 0, 32'hABC);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    expect_val("abort_busy", 3, 32'd0);
    expect_val("abort_done", 4, 32'd0);
    expect_val("abort_rd10", 0, 32'd0);
    step();
    expect_val("abort_idle", 3, 32'd0);
    clr_req = 1'b1;
    sweep("clr2", 1'b0);
    expect_val("post2_rd10", 0, 32'd0);
    @(negedge clk);
    #1;
    if (passed != total || total == 0) $display("FAIL summary: %0d/%0d checks passed", passed, total);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
